// File: rtl/ifetch_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
// The same RESET_VECTOR is used by pc_head_32, so both blocks agree on the boot address.
package ifetch_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0040_0020;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/dffr_a_32.sv
// 32-bit register with asynchronous active-low load of a fixed value and a clock enable.
module dffr_a_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aload,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // aload is tied to a constant at every instance, so this is a plain preset/clear flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= aload;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifetch_32.sv
// Single-outstanding instruction fetch: PC load -> memory request -> held instruction to decode.
// Optional misaligned-PC check is enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_load,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault
);
    import ifetch_pkg::*;

    // Handshakes: imem_req stays high with a stable imem_addr until imem_ack;
    // instr/instr_pc stay stable while instr_valid is high until instr_ready.
    fetch_state_t state;
    fetch_state_t next_state;

    logic        misaligned;
    logic        load_ok;
    logic        addr_en;
    logic        cap_en;
    logic [31:0] addr_q;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q;

    assign misaligned = (pc[1:0] != 2'b00);

    // Sticky until the next pc_load; an aligned load clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (pc_load) begin
            fault_q <= misaligned;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign load_ok = pc_load & ~misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        addr_en    = 1'b0;
        cap_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load_ok) begin
                    addr_en    = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                // A redirect wins over an ack in the same cycle; that response is dropped.
                if (pc_load) begin
                    addr_en    = load_ok;
                    next_state = load_ok ? ST_REQ : ST_IDLE;
                end else if (imem_ack) begin
                    cap_en     = 1'b1;
                    next_state = ST_HOLD;
                end else begin
                    next_state = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (pc_load) begin
                    addr_en    = load_ok;
                    next_state = load_ok ? ST_REQ : ST_IDLE;
                end else if (instr_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    dffr_a_32 u_addr_reg (
        .clk   (clk),
        .reset (reset),
        .aload (RESET_VECTOR),
        .en    (addr_en),
        .d     (pc),
        .q     (addr_q)
    );

    dffr_a_32 u_instr_reg (
        .clk   (clk),
        .reset (reset),
        .aload (NOP_INSTR),
        .en    (cap_en),
        .d     (imem_rdata),
        .q     (instr)
    );

    dffr_a_32 u_instr_pc_reg (
        .clk   (clk),
        .reset (reset),
        .aload (RESET_VECTOR),
        .en    (cap_en),
        .d     (addr_q),
        .q     (instr_pc)
    );

    assign imem_req    = (state == ST_REQ) || (state == ST_WAIT);
    assign imem_addr   = addr_q;
    assign instr_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_ifetch_32.sv
// Bench for ifetch_32: reset checks, a cycle table of fetch/redirect/backpressure
// sequences, async reset during WAIT, optional alignment check, and a random scoreboard run.
module tb_ifetch_32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_load;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;

    localparam logic [31:0] RV  = 32'h0040_0020;
    localparam logic [31:0] NOP = 32'h0000_0000;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        ld;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vt[$];

    ifetch_32 dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_load     (pc_load),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [31:0] p, input logic ack,
                         input logic [31:0] rd, input logic rdy);
        pc_load     = ld;
        pc          = p;
        imem_ack    = ack;
        imem_rdata  = rd;
        instr_ready = rdy;
    endtask

    task automatic add(input logic ld, input logic [31:0] p, input logic ack, input logic [31:0] rd,
                       input logic rdy, input logic e_req, input logic [31:0] e_addr,
                       input logic e_val, input logic [31:0] e_instr, input logic [31:0] e_ipc);
        vec_t v;
        v.ld = ld; v.pc = p; v.ack = ack; v.rd = rd; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_instr = e_instr; v.e_ipc = e_ipc;
        vt.push_back(v);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_req"},   {31'd0, imem_req},    32'd0);
        check({tag, "_addr"},  imem_addr,            RV);
        check({tag, "_instr"}, instr,                NOP);
        check({tag, "_ipc"},   instr_pc,             RV);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [63:0] e;
        int          d;
        bit          got;

        // Clock/reset: hold reset low three cycles.
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");
        reset = 1'b1;
        tick();

        // Cycle table: basic fetch, backpressure, redirect with same-cycle ack,
        // ack in REQ, drop in HOLD, accept+load, ack ignored in HOLD/IDLE.
        add(1, 32'h0040_0024, 0, 0,            0, 0, 0,            0, NOP,          RV);
        add(0, 0,             0, 0,            0, 1, 32'h0040_0024, 0, NOP,          RV);
        add(0, 0,             1, 32'h8C08_0004, 0, 1, 32'h0040_0024, 0, NOP,          RV);
        for (int i = 0; i < 5; i++)
            add(0, 0,         0, 0,            0, 0, 0,            1, 32'h8C08_0004, 32'h0040_0024);
        add(0, 0,             0, 0,            1, 0, 0,            1, 32'h8C08_0004, 32'h0040_0024);
        add(0, 0,             0, 0,            0, 0, 0,            0, 32'h8C08_0004, 32'h0040_0024);
        add(1, 32'h0040_0028, 0, 0,            0, 0, 0,            0, 32'h8C08_0004, 32'h0040_0024);
        add(0, 0,             0, 0,            0, 1, 32'h0040_0028, 0, 32'h8C08_0004, 32'h0040_0024);
        add(0, 0,             0, 0,            0, 1, 32'h0040_0028, 0, 32'h8C08_0004, 32'h0040_0024);
        add(1, 32'h0040_0100, 1, 32'hDEAD_BEEF, 0, 1, 32'h0040_0028, 0, 32'h8C08_0004, 32'h0040_0024);
        add(0, 0,             0, 0,            0, 1, 32'h0040_0100, 0, 32'h8C08_0004, 32'h0040_0024);
        add(0, 0,             1, 32'h1234_5678, 0, 1, 32'h0040_0100, 0, 32'h8C08_0004, 32'h0040_0024);
        add(0, 0,             0, 0,            1, 0, 0,            1, 32'h1234_5678, 32'h0040_0100);
        add(0, 0,             0, 0,            0, 0, 0,            0, 32'h1234_5678, 32'h0040_0100);
        add(1, 32'h0040_0200, 0, 0,            0, 0, 0,            0, 32'h1234_5678, 32'h0040_0100);
        add(0, 0,             1, 32'hAAAA_5555, 0, 1, 32'h0040_0200, 0, 32'h1234_5678, 32'h0040_0100);
        add(1, 32'h0040_0300, 0, 0,            0, 0, 0,            1, 32'hAAAA_5555, 32'h0040_0200);
        add(0, 0,             1, 32'h3333_3333, 0, 1, 32'h0040_0300, 0, 32'hAAAA_5555, 32'h0040_0200);
        add(1, 32'h0040_0400, 1, 32'h9999_9999, 1, 0, 0,            1, 32'h3333_3333, 32'h0040_0300);
        add(0, 0,             0, 0,            0, 1, 32'h0040_0400, 0, 32'h3333_3333, 32'h0040_0300);
        add(1, 32'h0040_0500, 0, 0,            0, 1, 32'h0040_0400, 0, 32'h3333_3333, 32'h0040_0300);
        add(0, 0,             0, 0,            0, 1, 32'h0040_0500, 0, 32'h3333_3333, 32'h0040_0300);
        add(0, 0,             1, 32'h0BAD_F00D, 0, 1, 32'h0040_0500, 0, 32'h3333_3333, 32'h0040_0300);
        add(0, 0,             0, 0,            1, 0, 0,            1, 32'h0BAD_F00D, 32'h0040_0500);
        add(0, 0,             1, 32'h7777_7777, 0, 0, 0,            0, 32'h0BAD_F00D, 32'h0040_0500);
        add(0, 0,             0, 0,            0, 0, 0,            0, 32'h0BAD_F00D, 32'h0040_0500);

        foreach (vt[i]) begin
            drive(vt[i].ld, vt[i].pc, vt[i].ack, vt[i].rd, vt[i].rdy);
            @(negedge clk);
            check($sformatf("row%0d_req", i),   {31'd0, imem_req},    {31'd0, vt[i].e_req});
            if (vt[i].e_req)
                check($sformatf("row%0d_addr", i), imem_addr, vt[i].e_addr);
            check($sformatf("row%0d_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].e_val});
            check($sformatf("row%0d_instr", i), instr,    vt[i].e_instr);
            check($sformatf("row%0d_ipc", i),   instr_pc, vt[i].e_ipc);
            check($sformatf("row%0d_fault", i), {31'd0, fetch_fault}, 32'd0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        // Async reset in WAIT: outputs return to reset values with no clock edge.
        drive(1'b1, 32'h0040_0600, 1'b0, 32'd0, 1'b0);
        tick();
        pc_load = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_idle_reset("async_rst");
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b1, 32'h5555_5555, 1'b0);
        tick();
        imem_ack = 1'b0;
        @(negedge clk);
        check_idle_reset("post_rst_ack");
        tick();

`ifdef IFETCH_ALIGN_CHECK_EN
        drive(1'b1, 32'h0040_0022, 1'b0, 32'd0, 1'b0);
        tick();
        pc_load = 1'b0;
        @(negedge clk);
        check("align_fault", {31'd0, fetch_fault}, 32'd1);
        check("align_noreq", {31'd0, imem_req},    32'd0);
        tick();
        @(negedge clk);
        check("align_sticky", {31'd0, fetch_fault}, 32'd1);
        check("align_noreq2", {31'd0, imem_req},    32'd0);
        tick();
        drive(1'b1, 32'h0040_0030, 1'b0, 32'd0, 1'b0);
        tick();
        pc_load = 1'b0;
        @(negedge clk);
        check("align_clear", {31'd0, fetch_fault}, 32'd0);
        check("align_req",   {31'd0, imem_req},    32'd1);
        check("align_addr",  imem_addr,            32'h0040_0030);
        tick();
        drive(1'b0, 32'd0, 1'b1, 32'h0000_1111, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        tick();
        instr_ready = 1'b0;
`endif

        // Random scoreboard run: random aligned PCs, ack latencies and ready delays.
        for (int t = 0; t < 20; t++) begin
            ra = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
            rd = $urandom();
            drive(1'b1, ra, 1'b0, 32'd0, 1'b0);
            tick();
            pc_load = 1'b0;
            @(negedge clk);
            check("rnd_req",  {31'd0, imem_req}, 32'd1);
            check("rnd_addr", imem_addr, ra);
            tick();
            d = $urandom_range(3, 0);
            repeat (d) tick();
            imem_ack   = 1'b1;
            imem_rdata = rd;
            exp_q.push_back({ra, rd});
            tick();
            imem_ack = 1'b0;
            d = $urandom_range(3, 0);
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                instr_ready = (k >= d);
                @(negedge clk);
                if (instr_valid && instr_ready) begin
                    got = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("rnd_queue_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rnd_instr", instr,    e[31:0]);
                        check("rnd_ipc",   instr_pc, e[63:32]);
                    end
                end
                tick();
            end
            instr_ready = 1'b0;
            check("rnd_valid_seen", {31'd0, got}, 32'd1);
            @(negedge clk);
            check("rnd_idle", {31'd0, instr_valid | imem_req}, 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_32.md
IFETCH_32 -- requirements
Module: ifetch_32

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock; all state registered on it.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: pc  input  32  fetch address from the PC register.
REQ-004 SHALL have port: pc_load  input  1  pulse; pc is a new fetch target this cycle.
REQ-005 SHALL have port: imem_req  output  1  read request to instruction memory.
REQ-006 SHALL have port: imem_addr  output  32  word address of the outstanding request.
REQ-007 SHALL have port: imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 SHALL have port: imem_rdata  input  32  instruction word.
REQ-009 SHALL have port: instr  output  32  fetched instruction to decode.
REQ-010 SHALL have port: instr_pc  output  32  address of instr.
REQ-011 SHALL have port: instr_valid  output  1  instr/instr_pc are valid.
REQ-012 SHALL have port: instr_ready  input  1  decode accepts instr this cycle.
REQ-013 SHALL have port: fetch_fault  output  1  misaligned-PC flag (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE, REQ, WAIT, HOLD; encoding from the shared package.
REQ-015 IDLE: pc_load -> latch pc into addr register, go REQ; otherwise stay.
REQ-016 REQ: imem_req=1, imem_addr=latched pc; next cycle WAIT, or HOLD directly if imem_ack is already high in REQ.
REQ-017 WAIT: imem_req held 1 with stable imem_addr until imem_ack; on ack capture imem_rdata into instr and the address into instr_pc, go HOLD.
REQ-018 HOLD: instr_valid=1; instr/instr_pc stay stable until instr_valid & instr_ready; on acceptance go IDLE, or REQ if pc_load is in the same cycle.
REQ-019 Latency: pc_load in cycle N -> imem_req in N+1; imem_ack in cycle M -> instr_valid in M+1.
REQ-020 pc_load in REQ/WAIT (redirect) SHALL relatch pc, discard any in-flight response (imem_ack that cycle is ignored), and restart in REQ; instr_valid stays 0.
REQ-021 pc_load in HOLD without instr_ready SHALL drop the held instruction (instr_valid=0 next cycle) and go REQ.
REQ-022 instr_valid SHALL never be 1 in the same cycle imem_req is 1.
REQ-023 imem_ack outside REQ/WAIT SHALL be ignored.
REQ-024 Addresses SHALL pass through unmodified, 32-bit, with no increment; next-PC arithmetic is outside this block.

Reset
REQ-025 reset low SHALL asynchronously force: state=IDLE, imem_req=0, imem_addr=RESET_VECTOR (0x00400020), instr=NOP_INSTR (0x00000000), instr_pc=RESET_VECTOR, instr_valid=0, fetch_fault=0.
REQ-026 Reset mid-transaction SHALL abandon the request; an imem_ack in the first cycle after release SHALL be ignored.

Configuration
REQ-027 Macro IFETCH_ALIGN_CHECK_EN defined: pc_load with pc[1:0]!=0 SHALL issue no request, set fetch_fault=1 (sticky until the next aligned pc_load or reset), and stay IDLE.
REQ-028 Macro undefined: no check is made; fetch_fault SHALL be tied 0 and pc[1:0] is forwarded unchanged.

Structure
REQ-029 Shared package ifetch_pkg SHALL hold RESET_VECTOR, NOP_INSTR and the FSM state encoding; pc_head_32 SHALL use the same RESET_VECTOR.
REQ-030 The instr, instr_pc and address registers SHALL be instances of the existing dffr_a_32 (aload=reset vector/NOP, enable=capture); no other sub-module.

Verification
REQ-031 Reset: hold reset low 3 cycles -> instr_pc=0x00400020, instr=0, instr_valid=0, imem_req=0.
REQ-032 Basic fetch: pc_load with pc=0x00400024 in cycle 1, ack with rdata=0x8C080004 in cycle 3 -> imem_req in cycles 2-3, instr_valid in cycle 4 with instr=0x8C080004, instr_pc=0x00400024.
REQ-033 Backpressure: instr_ready=0 for 5 cycles -> instr stays stable and valid; ready=1 -> IDLE next cycle.
REQ-034 Redirect: pc_load with 0x00400100 while waiting on 0x00400028 and ack in the same cycle -> old data discarded; next request is 0x00400100.
REQ-035 Alignment: IFETCH_ALIGN_CHECK_EN defined, pc_load with pc=0x00400022 -> fetch_fault=1, no imem_req; a following aligned pc_load clears it.
REQ-036 Async reset asserted during WAIT -> all outputs at reset values immediately, without a clock edge.
